// File: rtl/cpu_run_stat_unit.sv
// cpu_run_stat_unit
// Run control for the single-cycle CPU: it owns the PC / regfile write
// enable and the RUN / PAUSE / HOLD / EXIT sequencing driven by syscalls,
// the go button and an external hold. It also holds a bank of event
// counters and the registered LED display multiplexer.

module cpu_run_stat_unit #(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned N_EVT     = 3,
  parameter int unsigned SEL_W     = 3,
  parameter bit          SATURATE  = 1'b0,
  parameter logic [31:0] SYS_EXIT  = 32'h0000000A,
  parameter logic [31:0] SYS_PRINT = 32'h00000022
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             ext_hold,
  input  logic             sys_valid,
  input  logic [31:0]      sys_code,
  input  logic [31:0]      sys_arg,
  input  logic [N_EVT-1:0] evt,
  input  logic             cnt_clr,
  input  logic [SEL_W-1:0] s_type,
  input  logic [31:0]      mem_data,
  output logic             run,
  output logic             halt,
  output logic             exited,
  output logic [31:0]      led_data
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PAUSE = 2'd1,
    ST_EXIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  // Counter bank: index 0 is the run-cycle counter, 1..N_EVT follow evt[].
  localparam int unsigned N_CNT = N_EVT + 1;

  state_t             state_r;
  state_t             state_nxt_s;
  state_t             ret_r;
  state_t             ret_nxt_s;
  logic               resume_mask_r;
  logic               mask_nxt_s;
  logic               go_q_r;
  logic               go_edge_s;
  logic               print_s;
  logic [31:0]        sys_out_r;

  logic               run_r;
  logic               halt_r;
  logic               exited_r;
  logic               run_nxt_s;
  logic               exited_nxt_s;
  logic [31:0]        led_r;
  logic [31:0]        disp_s;
  logic [31:0]        sel_idx_s;

  logic [CNT_W-1:0]   cnt_r      [0:N_CNT-1];
  logic               inc_s      [0:N_CNT-1];
  logic [31:0]        cnt_disp_s [0:N_CNT-1];

  // One-step counter advance; in saturating mode an all-ones value sticks.
  function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (SATURATE && (&v)) begin
      r = v;
    end else begin
      r = v + CNT_W'(1);
    end
    return r;
  endfunction

  assign go_edge_s = go & ~go_q_r;

  // go is a level input; remember last cycle's value for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      go_q_r <= 1'b0;
    end else begin
      go_q_r <= go;
    end
  end

  // FSM state register with the HOLD return target and the resume mask.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_RUN;
      ret_r         <= ST_RUN;
      resume_mask_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      ret_r         <= ret_nxt_s;
      resume_mask_r <= mask_nxt_s;
    end
  end

  // Next-state logic: hold beats syscalls, a masked syscall is ignored.
  always_comb begin
    state_nxt_s = state_r;
    ret_nxt_s   = ret_r;
    mask_nxt_s  = resume_mask_r;
    print_s     = 1'b0;
    case (state_r)
      ST_RUN: begin
        // The mask only ever covers the first RUN cycle after a resume.
        mask_nxt_s = 1'b0;
        if (ext_hold) begin
          state_nxt_s = ST_HOLD;
          ret_nxt_s   = ST_RUN;
        end else if (sys_valid && !resume_mask_r) begin
          if (sys_code == SYS_EXIT) begin
            state_nxt_s = ST_EXIT;
          end else if (sys_code == SYS_PRINT) begin
            print_s     = 1'b1;
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_PAUSE;
          end
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (ext_hold) begin
          state_nxt_s = ST_HOLD;
          ret_nxt_s   = ST_PAUSE;
        end else if (go_edge_s) begin
          // The stalled syscall is still on the bus; mask it for one cycle.
          state_nxt_s = ST_RUN;
          mask_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = ST_PAUSE;
        end
      end
      ST_HOLD: begin
        if (!ext_hold) begin
          state_nxt_s = ret_r;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      ST_EXIT: begin
        state_nxt_s = ST_EXIT;
      end
      default: begin
        state_nxt_s = ST_RUN;
        ret_nxt_s   = ST_RUN;
        mask_nxt_s  = 1'b0;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs track state_r.
  always_comb begin
    run_nxt_s    = 1'b0;
    exited_nxt_s = 1'b0;
    case (state_nxt_s)
      ST_RUN:   run_nxt_s    = 1'b1;
      ST_EXIT:  exited_nxt_s = 1'b1;
      ST_PAUSE: run_nxt_s    = 1'b0;
      ST_HOLD:  run_nxt_s    = 1'b0;
      default:  run_nxt_s    = 1'b0;
    endcase
  end

  // Registered run-control outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_r    <= 1'b1;
      halt_r   <= 1'b0;
      exited_r <= 1'b0;
    end else begin
      run_r    <= run_nxt_s;
      halt_r   <= ~run_nxt_s;
      exited_r <= exited_nxt_s;
    end
  end

  // Print syscall latches its argument for the display.
  always_ff @(posedge clk) begin
    if (rst) begin
      sys_out_r <= 32'd0;
    end else if (print_s) begin
      sys_out_r <= sys_arg;
    end else begin
      sys_out_r <= sys_out_r;
    end
  end

  // Per-counter increment requests, all qualified by run.
  always_comb begin
    inc_s[0] = run_r;
    for (int i = 0; i < N_EVT; i++) begin
      inc_s[i + 1] = run_r & evt[i];
    end
  end

  // Counter bank: reset, then clear, then increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      for (int k = 0; k < N_CNT; k++) begin
        cnt_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_CNT; k++) begin
        if (inc_s[k]) begin
          cnt_r[k] <= cnt_step(cnt_r[k]);
        end else begin
          cnt_r[k] <= cnt_r[k];
        end
      end
    end
  end

  // Fit every counter to the 32-bit display bus.
  for (genvar k = 0; k < N_CNT; k++) begin : g_cnt_disp
    if (CNT_W >= 32) begin : g_trunc
      assign cnt_disp_s[k] = cnt_r[k][31:0];
    end else begin : g_ext
      assign cnt_disp_s[k] = {{(32 - CNT_W){1'b0}}, cnt_r[k]};
    end
  end

  // Display select: 0 = print value, 1..N_CNT = counters, otherwise RAM data.
  always_comb begin
    sel_idx_s = 32'(s_type);
    disp_s    = mem_data;
    if (sel_idx_s == 32'd0) begin
      disp_s = sys_out_r;
    end else begin
      for (int k = 0; k < N_CNT; k++) begin
        disp_s = (sel_idx_s == 32'(k + 1)) ? cnt_disp_s[k] : disp_s;
      end
    end
  end

  // Display register refreshes every cycle regardless of run state.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_r <= 32'd0;
    end else begin
      led_r <= disp_s;
    end
  end

  assign run      = run_r;
  assign halt     = halt_r;
  assign exited   = exited_r;
  assign led_data = led_r;

endmodule

// File: tb/tb_cpu_run_stat_unit.sv
// Bench for cpu_run_stat_unit: three instances (32-bit wrapping, 4-bit
// wrapping, 4-bit saturating) share one stimulus stream and are checked
// every cycle against a flag-based behavioural model with unbounded counts.

module tb_cpu_run_stat_unit;
  localparam int N_EVT = 3;
  localparam int N_DUT = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             go;
  logic             ext_hold;
  logic             sys_valid;
  logic [31:0]      sys_code;
  logic [31:0]      sys_arg;
  logic [N_EVT-1:0] evt;
  logic             cnt_clr;
  logic [2:0]       s_type;
  logic [31:0]      mem_data;

  logic             run_w    [N_DUT];
  logic             halt_w   [N_DUT];
  logic             exited_w [N_DUT];
  logic [31:0]      led_w    [N_DUT];

  int n_vec  = 0;
  int n_miss = 0;

  // Behavioural model: independent flags, true event counts since clear.
  bit          m_exited;
  bit          m_paused;
  bit          m_held;
  bit          m_mask;
  bit          m_go_q;
  logic [31:0] m_sysout;
  longint      m_cnt [N_EVT + 1];
  logic [31:0] m_led [N_DUT];

  always #5 clk = ~clk;

  cpu_run_stat_unit #(.CNT_W(32), .N_EVT(N_EVT), .SEL_W(3), .SATURATE(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .go(go), .ext_hold(ext_hold), .sys_valid(sys_valid),
    .sys_code(sys_code), .sys_arg(sys_arg), .evt(evt), .cnt_clr(cnt_clr),
    .s_type(s_type), .mem_data(mem_data), .run(run_w[0]), .halt(halt_w[0]),
    .exited(exited_w[0]), .led_data(led_w[0]));

  cpu_run_stat_unit #(.CNT_W(4), .N_EVT(N_EVT), .SEL_W(3), .SATURATE(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .go(go), .ext_hold(ext_hold), .sys_valid(sys_valid),
    .sys_code(sys_code), .sys_arg(sys_arg), .evt(evt), .cnt_clr(cnt_clr),
    .s_type(s_type), .mem_data(mem_data), .run(run_w[1]), .halt(halt_w[1]),
    .exited(exited_w[1]), .led_data(led_w[1]));

  cpu_run_stat_unit #(.CNT_W(4), .N_EVT(N_EVT), .SEL_W(3), .SATURATE(1'b1)) u_dut2 (
    .clk(clk), .rst(rst), .go(go), .ext_hold(ext_hold), .sys_valid(sys_valid),
    .sys_code(sys_code), .sys_arg(sys_arg), .evt(evt), .cnt_clr(cnt_clr),
    .s_type(s_type), .mem_data(mem_data), .run(run_w[2]), .halt(halt_w[2]),
    .exited(exited_w[2]), .led_data(led_w[2]));

  function automatic bit m_running();
    return !m_exited && !m_paused && !m_held;
  endfunction

  // How instance d shows a true count c.
  function automatic logic [31:0] view(input int d, input longint c);
    if (d == 0) return 32'(c % 64'sd4294967296);
    else if (d == 1) return 32'(c % 64'sd16);
    else return (c > 64'sd15) ? 32'd15 : 32'(c);
  endfunction

  function automatic logic [31:0] disp(input int d);
    int sel;
    sel = int'(s_type);
    if (sel == 0) return m_sysout;
    else if (sel <= N_EVT + 1) return view(d, m_cnt[sel - 1]);
    else return mem_data;
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit go_edge;
    bit was_masked;
    go_edge = go && !m_go_q;
    for (int d = 0; d < N_DUT; d++) m_led[d] = rst ? 32'd0 : disp(d);
    if (rst) begin
      m_exited = 1'b0; m_paused = 1'b0; m_held = 1'b0; m_mask = 1'b0;
      m_go_q = 1'b0; m_sysout = 32'd0;
      for (int k = 0; k <= N_EVT; k++) m_cnt[k] = 0;
    end else begin
      if (cnt_clr) begin
        for (int k = 0; k <= N_EVT; k++) m_cnt[k] = 0;
      end else if (m_running()) begin
        m_cnt[0] = m_cnt[0] + 1;
        for (int k = 0; k < N_EVT; k++) m_cnt[k + 1] = m_cnt[k + 1] + longint'(evt[k]);
      end
      m_go_q = go;
      if (m_exited) begin
        m_exited = 1'b1;
      end else if (m_held) begin
        if (!ext_hold) m_held = 1'b0;
      end else if (m_paused) begin
        if (ext_hold) m_held = 1'b1;
        else if (go_edge) begin
          m_paused = 1'b0;
          m_mask   = 1'b1;
        end
      end else begin
        was_masked = m_mask;
        m_mask = 1'b0;
        if (ext_hold) m_held = 1'b1;
        else if (sys_valid && !was_masked) begin
          if (sys_code == 32'h0000000A) m_exited = 1'b1;
          else if (sys_code == 32'h00000022) m_sysout = sys_arg;
          else m_paused = 1'b1;
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison of all instances against the model.
  task automatic check_all();
    bit er;
    er = m_running();
    for (int d = 0; d < N_DUT; d++) begin
      check($sformatf("run%0d", d),    {31'd0, run_w[d]},    {31'd0, er});
      check($sformatf("halt%0d", d),   {31'd0, halt_w[d]},   {31'd0, ~er});
      check($sformatf("exited%0d", d), {31'd0, exited_w[d]}, {31'd0, m_exited});
      check($sformatf("led%0d", d),    led_w[d],             m_led[d]);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; ext_hold = 1'b0; sys_valid = 1'b0; cnt_clr = 1'b0;
    sys_code = 32'd0; sys_arg = 32'd0; evt = 3'd0; s_type = 3'd0;
    mem_data = 32'hA5A50001;
    tick(); tick();
    check("pin_rst_run", {31'd0, run_w[0]}, 32'd1);
    check("pin_rst_halt", {31'd0, halt_w[0]}, 32'd0);
    check("pin_rst_exited", {31'd0, exited_w[0]}, 32'd0);
    check("pin_rst_led", led_w[0], 32'd0);

    // Ten free-running cycles, then a print syscall.
    rst = 1'b0;
    repeat (10) tick();
    sys_valid = 1'b1; sys_code = 32'h22; sys_arg = 32'h1234;
    tick();
    check("pin_print_run", {31'd0, run_w[0]}, 32'd1);
    sys_valid = 1'b0; s_type = 3'd1;
    tick();
    check("pin_cycles_11", led_w[0], 32'd11);
    check("pin_model_cycles_11", m_led[0], 32'd11);
    s_type = 3'd0;
    tick();
    check("pin_print_led", led_w[0], 32'h1234);

    // Pause syscall, resume with the syscall still asserted.
    sys_valid = 1'b1; sys_code = 32'h5;
    tick();
    check("pin_pause_run", {31'd0, run_w[0]}, 32'd0);
    check("pin_pause_halt", {31'd0, halt_w[0]}, 32'd1);
    repeat (3) tick();
    go = 1'b1;
    tick();
    check("pin_resume_run", {31'd0, run_w[0]}, 32'd1);
    go = 1'b0;
    tick();
    check("pin_mask_run", {31'd0, run_w[0]}, 32'd1);
    sys_valid = 1'b0;
    tick();
    check("pin_cont_run", {31'd0, run_w[0]}, 32'd1);

    // Exit is terminal against go and ext_hold.
    sys_valid = 1'b1; sys_code = 32'hA;
    tick();
    sys_valid = 1'b0;
    check("pin_exit_exited", {31'd0, exited_w[0]}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      go = (i % 2 == 0); ext_hold = (i >= 3);
      tick();
    end
    go = 1'b0; ext_hold = 1'b0;
    tick();
    check("pin_exit_stay", {31'd0, exited_w[0]}, 32'd1);
    check("pin_exit_run", {31'd0, run_w[0]}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0; s_type = 3'd1;
    tick();
    check("pin_exit_rst_cnt", led_w[0], 32'd0);
    check("pin_exit_rst_run", {31'd0, run_w[0]}, 32'd1);

    // External hold from RUN and from PAUSE.
    s_type = 3'd7; mem_data = 32'hCAFEF00D; ext_hold = 1'b1;
    repeat (5) tick();
    ext_hold = 1'b0;
    tick();
    check("pin_mem_led", led_w[0], 32'hCAFEF00D);
    tick();
    check("pin_hold_ret_run", {31'd0, run_w[0]}, 32'd1);
    sys_valid = 1'b1; sys_code = 32'h7;
    tick();
    sys_valid = 1'b0; ext_hold = 1'b1;
    repeat (3) tick();
    ext_hold = 1'b0;
    repeat (2) tick();
    check("pin_hold_ret_pause", {31'd0, run_w[0]}, 32'd0);
    go = 1'b1;
    tick();
    go = 1'b0;
    check("pin_unpause", {31'd0, run_w[0]}, 32'd1);

    // Clear beats increment, then 20 evt[0] cycles.
    s_type = 3'd0; cnt_clr = 1'b1; evt = 3'b001;
    tick();
    cnt_clr = 1'b0; evt = 3'd0; s_type = 3'd2;
    tick();
    check("pin_clr_wins", led_w[0], 32'd0);
    evt = 3'b001;
    repeat (20) tick();
    evt = 3'd0;
    tick();
    check("pin_evt_32", led_w[0], 32'd20);
    check("pin_evt_wrap4", led_w[1], 32'd4);
    check("pin_evt_sat4", led_w[2], 32'd15);
    check("pin_model_wrap4", m_led[1], 32'd4);
    check("pin_model_sat4", m_led[2], 32'd15);

    // Reset in the middle of a pause.
    sys_valid = 1'b1; sys_code = 32'h5;
    tick();
    sys_valid = 1'b0;
    tick();
    check("pin_midpause_run", {31'd0, run_w[0]}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("pin_midpause_led", led_w[0], 32'd0);
    check("pin_midpause_rst_run", {31'd0, run_w[0]}, 32'd1);

    // Randomised traffic.
    for (int n = 0; n < 4000; n++) begin
      rst       = ($urandom_range(0, 99) == 0);
      go        = ($urandom_range(0, 2) == 0);
      ext_hold  = ($urandom_range(0, 7) == 0);
      sys_valid = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 9))
        0:       sys_code = 32'hA;
        1, 2, 3: sys_code = 32'h22;
        default: sys_code = $urandom_range(0, 40);
      endcase
      sys_arg  = $urandom;
      cnt_clr  = ($urandom_range(0, 49) == 0);
      evt      = 3'($urandom);
      s_type   = 3'($urandom);
      mem_data = $urandom;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/cpu_run_stat_unit.md
Name: cpu_run_stat_unit

Overview:
Parametrised run-control and statistics unit for the single-cycle CPU family. It owns the PC/regfile write-enable (`run`) and the halt/pause/exit state machine driven by syscalls, `go` and an external hold. It also holds a bank of configurable event counters and the registered LED display multiplexer. It replaces the ad-hoc halt logic and fixed 3-counter statistics inside the CPU datapath.

Parameters:
CNT_W, 32, width of each statistics counter (1..32 displayed; wider values are truncated to the low 32 bits on `led_data`).
N_EVT, 3, number of event counters in addition to the cycle counter (1..6).
SEL_W, 3, width of `s_type`.
SATURATE, 0, 0 = counters wrap at 2^CNT_W; 1 = counters stick at all-ones.
SYS_EXIT, 32'h0000000A, `sys_code` value meaning program exit.
SYS_PRINT, 32'h00000022, `sys_code` value meaning print `sys_arg` to the display.

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  synchronous, active-high reset
go  in  1  resume request; level input, rising edge detected internally
ext_hold  in  1  external interrupt/inspect hold; freezes the CPU while high
sys_valid  in  1  a syscall instruction is in the current cycle
sys_code  in  32  syscall selector ($v0)
sys_arg  in  32  syscall argument ($a0)
evt  in  N_EVT  per-cycle event pulses (e.g. evt[0]=jump, evt[1]=branch taken)
cnt_clr  in  1  synchronous clear of all counters
s_type  in  SEL_W  display select
mem_data  in  32  RAM data for memory display
run  out  1  PC enable / regfile write qualifier
halt  out  1  equals ~run
exited  out  1  program has executed the exit syscall
led_data  out  32  registered display value

Behaviour:
- Reset values: state=RUN, `run`=1, `halt`=0, `exited`=0, `led_data`=0, sys_out=0, all counters=0, go_q=0, resume_mask=0. `rst` overrides every other input.
- `go_edge` = go & ~go_q, where go_q is a register.
- States are RUN, PAUSE, EXIT and HOLD. `run`=1 only in RUN; it is a registered output.
- RUN:
  - `ext_hold` -> HOLD (ret=RUN).
  - Else if `sys_valid` & ~resume_mask:
    - code==SYS_EXIT -> EXIT.
    - code==SYS_PRINT -> sys_out<=sys_arg; stay in RUN.
    - Any other code -> PAUSE.
- PAUSE: `ext_hold` -> HOLD (ret=PAUSE). Else `go_edge` -> RUN and set resume_mask=1.
- HOLD: when `ext_hold`=0 -> ret. `go` is ignored while in HOLD.
- EXIT: terminal; only `rst` leaves it. `exited`=1. `ext_hold` has no effect.
- resume_mask:
  - Set only on the PAUSE->RUN transition.
  - Cleared after exactly one RUN cycle.
  - While set, `sys_valid` is ignored. This prevents the stalled syscall from re-pausing the CPU.
- Syscall timing: the syscall cycle itself has `run`=1 and is counted. `run` falls on the following cycle (one-cycle latency).
- Counters: cnt[0] counts every cycle with `run`=1. cnt[i+1] increments when `run` & evt[i]. With SATURATE=1, all-ones holds.
- Counter clear priority: rst > cnt_clr > increment.
- Display: `led_data` is registered every cycle (one-cycle latency).
  - s_type==0 -> sys_out.
  - s_type==k, 1<=k<=N_EVT+1 -> cnt[k-1], zero-extended or truncated to 32 bits.
  - Otherwise -> `mem_data`.
- Display is live in all states, including EXIT and HOLD.
- A print syscall in the same cycle as `ext_hold` is dropped; HOLD wins.

Test Plan:
- Release rst, `evt`=0, run 10 cycles, then print syscall with code=0x22, arg=0x1234, s_type=0 -> `led_data`=0x1234 two cycles later; `run` stays 1; s_type=1 shows 11.
- Syscall code=0x5 -> `run`=0 next cycle; cnt[0] frozen. Hold `sys_valid`=1 and pulse `go` -> `run`=1 for one cycle with no re-pause. Drop `sys_valid` -> RUN continues.
- Exit syscall code=0xA -> `exited`=1, `run`=0. Further `go` pulses and `ext_hold` have no effect. rst -> RUN with all counters 0.
- `ext_hold` high for 5 cycles during RUN -> `run`=0 for exactly those cycles; counters do not advance; s_type=7 shows `mem_data`. Repeat from PAUSE -> returns to PAUSE, not RUN.
- CNT_W=4, SATURATE=0, evt[0]=1 for 20 run cycles -> cnt[1]=4. With SATURATE=1 -> cnt[1]=15.
- `cnt_clr` and `evt[0]` asserted in the same cycle -> cnt[1]=0 next cycle. rst asserted mid-PAUSE -> RUN, `led_data`=0 the following cycle.
